// File: rtl/cm_arb_pri_rr.sv
// cm_arb_pri_rr -- registered priority arbiter with round-robin tie break.
//
// Purpose:
//   Sits in front of a bus-matrix slave-side mux. Requesters are first masked
//   down to the highest active priority level. Any tie among the survivors is
//   then broken round-robin, starting after the last winner. A locked owner
//   that is still requesting keeps the grant. While arb_en_i is low, the whole
//   grant state is frozen.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   req_i      request, one bit per requester
//   pri_i      priority of requester i at pri_i[i*PRI_WIDTH +: PRI_WIDTH]
//   lock_i     owner keeps its grant while lock_i[i] & req_i[i]
//   arb_en_i   arbitration allowed this cycle (HREADY-style)
//   gnt_o      registered one-hot grant, 0 when idle
//   gnt_id_o   index of granted requester
//   gnt_pri_o  raw pri_i of the winner, captured at grant time
//   gnt_vld_o  gnt_o != 0
//
// Configuration macro: CM_ARB_PRI_AGING_EN
//   When defined, a requester that has waited AGE_LIMIT cycles competes at
//   all-ones priority until it is granted.

module cm_arb_pri_rr #(
    parameter int REQ_NUM   = 4,
    parameter int PRI_WIDTH = 2,
    parameter int ID_WIDTH  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    parameter int AGE_WIDTH = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REQ_NUM-1:0]             req_i,
    input  logic [PRI_WIDTH*REQ_NUM-1:0]   pri_i,
    input  logic [REQ_NUM-1:0]             lock_i,
    input  logic                           arb_en_i,
    output logic [REQ_NUM-1:0]             gnt_o,
    output logic [ID_WIDTH-1:0]            gnt_id_o,
    output logic [PRI_WIDTH-1:0]           gnt_pri_o,
    output logic                           gnt_vld_o
);

    // The aging threshold has to be reachable by the counter.
    if (AGE_LIMIT > (2**AGE_WIDTH) - 1) begin : g_bad_age
        $error("AGE_LIMIT does not fit in AGE_WIDTH bits");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [REQ_NUM-1:0]     gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]    gnt_id_q, gnt_id_d;
    logic [PRI_WIDTH-1:0]   gnt_pri_q, gnt_pri_d;
    logic [ID_WIDTH-1:0]    rr_q, rr_d;

    logic [REQ_NUM-1:0][PRI_WIDTH-1:0] eff_pri;
    logic [PRI_WIDTH-1:0]   max_pri;
    logic [REQ_NUM-1:0]     cand;
    logic                   found;
    logic [ID_WIDTH-1:0]    win_id;
    logic [REQ_NUM-1:0]     win_oh;
    logic [PRI_WIDTH-1:0]   win_pri;
    logic                   owner_hold;
    logic                   arb;

`ifdef CM_ARB_PRI_AGING_EN
    logic [REQ_NUM-1:0][AGE_WIDTH-1:0] age_q, age_d;
`endif

    // Effective priority: raw input, promoted to all-ones once aged out.
    always_comb begin
        eff_pri = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            eff_pri[i] = pri_i[i*PRI_WIDTH +: PRI_WIDTH];
`ifdef CM_ARB_PRI_AGING_EN
            if (age_q[i] == AGE_WIDTH'(AGE_LIMIT)) eff_pri[i] = '1;
`endif
        end
    end

    // Highest level among active requesters, then mask to that level.
    always_comb begin
        max_pri = '0;
        cand    = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (req_i[i] && eff_pri[i] > max_pri) max_pri = eff_pri[i];
        for (int i = 0; i < REQ_NUM; i++)
            cand[i] = req_i[i] && (eff_pri[i] == max_pri);
    end

    // Round-robin scan starting one past the previous winner.
    always_comb begin : p_win
        int idx;
        idx     = 0;
        found   = 1'b0;
        win_id  = '0;
        win_oh  = '0;
        win_pri = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            idx = (int'(rr_q) + k) % REQ_NUM;
            if (!found && cand[idx]) begin
                found       = 1'b1;
                win_id      = ID_WIDTH'(idx);
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_pri     = pri_i[idx*PRI_WIDTH +: PRI_WIDTH];
            end
        end
    end

    // gnt_q is one-hot or zero, so this is lock[owner] & req[owner].
    assign owner_hold = |(lock_i & req_i & gnt_q);
    assign arb        = arb_en_i && ((state_q == IDLE) || !owner_hold);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_pri_d = gnt_pri_q;
        rr_d      = rr_q;
        if (arb) begin
            if (found) begin
                state_d   = BUSY;
                gnt_d     = win_oh;
                gnt_id_d  = win_id;
                gnt_pri_d = win_pri;
                rr_d      = win_id;
            end else begin
                // Nobody asking: release the bus, keep the RR pointer.
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_pri_q <= '0;
            rr_q      <= ID_WIDTH'(REQ_NUM - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_pri_q <= gnt_pri_d;
            rr_q      <= rr_d;
        end
    end

`ifdef CM_ARB_PRI_AGING_EN
    // Waiting time per requester; saturates at AGE_LIMIT so the promotion
    // sticks until the requester is finally granted or withdraws.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!req_i[i] || (arb && found && win_oh[i]))
                age_d[i] = '0;
            else if (!gnt_q[i] && age_q[i] != AGE_WIDTH'(AGE_LIMIT))
                age_d[i] = age_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) age_q <= '0;
        else       age_q <= age_d;
    end
`endif

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign gnt_pri_o = gnt_pri_q;
    assign gnt_vld_o = |gnt_q;

endmodule
